// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the MUSA instruction-fetch stage.
// Holds the sequencer state encoding, fetch constants and the PC legality check.
package musa_if_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] IF_NOP    = 32'h0000_0000;
    localparam logic [31:0] IF_PC_INC = 32'd4;

    // A PC is fetchable when it is word-aligned and its word index lies inside the memory.
    function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned depth);
        return (pc[1:0] == 2'b00) && ((pc >> 2) < depth);
    endfunction

endpackage

// File: rtl/fetch_sequencer_hold_buffer.sv
// One-entry instruction/PC holding register for the fetch stage.
// Captures the live memory word and its PC on load; sel picks held versus live values.
module fetch_hold_buffer
    import musa_if_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic        sel_i,
    input  logic [31:0] live_instr_i,
    input  logic [31:0] live_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    always_comb begin
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if (load_i) begin
            hold_instr_d = live_instr_i;
            hold_pc_d    = live_pc_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_instr_q <= IF_NOP;
            hold_pc_q    <= '0;
        end else begin
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign instr_o = sel_i ? hold_instr_q : live_instr_i;
    assign pc_o    = sel_i ? hold_pc_q    : live_pc_i;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage fetch controller: drives the registered instruction memory, pairs returned
// words with their PC, holds one instruction under stall, and applies redirects/faults.
module fetch_sequencer
    import musa_if_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  out_pc_q, out_pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic         hold_load;
    logic         hold_sel;
    logic         consume;
    logic         advance;
    logic [31:0]  buf_instr;
    logic [31:0]  buf_pc;

    assign valid_o  = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign hold_sel = (state_q == ST_HOLD);
    assign consume  = valid_o && !stall_i;
    // FILL always moves forward; the memory word for pc_q arrives on the next cycle.
    assign advance  = (state_q == ST_FILL) || consume;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        out_pc_d   = out_pc_q;
        fault_pc_d = fault_pc_q;
        hold_load  = 1'b0;
        if (redirect_valid_i) begin
            if (pc_in_range(redirect_pc_i, MEM_DEPTH)) begin
                pc_d    = redirect_pc_i;
                state_d = ST_FILL;
            end else begin
                fault_pc_d = redirect_pc_i;
                state_d    = ST_FAULT;
            end
        end else if ((state_q == ST_RUN) && stall_i) begin
            hold_load = 1'b1;
            state_d   = ST_HOLD;
        end else if (advance) begin
            if (pc_in_range(pc_q, MEM_DEPTH)) begin
                out_pc_d = pc_q;
                pc_d     = pc_q + IF_PC_INC;
                state_d  = ST_RUN;
            end else begin
                fault_pc_d = pc_q;
                state_d    = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL;
            pc_q       <= RESET_PC;
            out_pc_q   <= RESET_PC;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            out_pc_q   <= out_pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_hold_buffer u_hold (
        .clock        (clock),
        .reset        (reset),
        .load_i       (hold_load),
        .sel_i        (hold_sel),
        .live_instr_i (imem_data_i),
        .live_pc_i    (out_pc_q),
        .instr_o      (buf_instr),
        .pc_o         (buf_pc)
    );

    assign instr_o     = valid_o ? buf_instr : IF_NOP;
    assign pc_o        = buf_pc;
    assign fault_o     = (state_q == ST_FAULT);
    assign fault_pc_o  = fault_pc_q;
    assign imem_addr_o = fault_o ? 32'h0 : {2'b00, pc_q[31:2]};

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random redirect/stall traffic,
// all compared against a delivery-order model of the fetch stream.
module tb_fetch_sequencer;

    localparam int unsigned DEPTH = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i = 32'h0;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        fault_o;
    logic [31:0] fault_pc_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: the stream is "PC m_pc is being filled" (!m_valid) or "PC m_pc is on offer".
    bit          m_valid;
    bit          m_fault;
    logic [31:0] m_pc;
    logic [31:0] m_fpc;

    always #5 clock = ~clock;

    fetch_sequencer #(
        .MEM_DEPTH (DEPTH),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_addr_o      (imem_addr_o),
        .imem_data_i      (imem_data_i),
        .valid_o          (valid_o),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .fault_o          (fault_o),
        .fault_pc_o       (fault_pc_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] widx);
        return (widx < DEPTH) ? (32'hA000_0000 + widx) : 32'hDEAD_BEEF;
    endfunction

    always @(posedge clock) imem_data_i <= mem_word(imem_addr_o);

    function automatic bit legal(input logic [31:0] pc);
        return ((pc % 4) == 0) && (pc < 4 * DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_pc    = 32'h0;
        m_fpc   = 32'h0;
    endtask

    task automatic model_step();
        if (redirect_valid_i) begin
            m_valid = 1'b0;
            if (legal(redirect_pc_i)) begin
                m_fault = 1'b0;
                m_pc    = redirect_pc_i;
            end else begin
                m_fault = 1'b1;
                m_fpc   = redirect_pc_i;
            end
        end else if (m_fault) begin
            m_fault = 1'b1;
        end else if (!m_valid) begin
            if (legal(m_pc)) m_valid = 1'b1;
            else begin
                m_fault = 1'b1;
                m_fpc   = m_pc;
            end
        end else if (!stall_i) begin
            if (legal(m_pc + 32'd4)) m_pc = m_pc + 32'd4;
            else begin
                m_valid = 1'b0;
                m_fault = 1'b1;
                m_fpc   = m_pc + 32'd4;
            end
        end
    endtask

    task automatic check_model();
        logic [31:0] exp_addr;
        if (m_fault)      exp_addr = 32'h0;
        else if (m_valid) exp_addr = (m_pc + 32'd4) / 4;
        else              exp_addr = m_pc / 4;
        chk("valid", {31'h0, valid_o}, {31'h0, m_valid});
        chk("fault", {31'h0, fault_o}, {31'h0, m_fault});
        chk("addr", imem_addr_o, exp_addr);
        if (m_valid) begin
            chk("instr", instr_o, 32'hA000_0000 + m_pc / 4);
            chk("pc", pc_o, m_pc);
        end else begin
            chk("nop", instr_o, 32'h0);
        end
        if (m_fault) chk("fault_pc", fault_pc_o, m_fpc);
    endtask

    task automatic at_neg(input bit r, input logic [31:0] rpc, input bit s);
        redirect_valid_i = r;
        redirect_pc_i    = rpc;
        stall_i          = s;
        @(negedge clock);
        check_model();
    endtask

    task automatic tick();
        @(posedge clock);
        if (!reset) model_step();
        #1;
    endtask

    task automatic cyc(input bit r, input logic [31:0] rpc, input bit s);
        at_neg(r, rpc, s);
        tick();
    endtask

    initial begin
        bit          r;
        bit          s;
        int          kind;
        logic [31:0] rpc;

        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_fault", {31'h0, fault_o}, 32'h0);
        chk("rst_fault_pc", fault_pc_o, 32'h0);
        chk("rst_addr", imem_addr_o, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        // Reset release and straight-line fetch
        at_neg(0, 0, 0);
        chk("t1_c0_valid", {31'h0, valid_o}, 32'h0);
        chk("t1_c0_addr", imem_addr_o, 32'h0);
        tick();
        at_neg(0, 0, 0);
        chk("t1_c1_valid", {31'h0, valid_o}, 32'h1);
        chk("t1_c1_instr", instr_o, 32'hA000_0000);
        chk("t1_c1_pc", pc_o, 32'h0);
        tick();
        at_neg(0, 0, 0);
        chk("t1_c2_instr", instr_o, 32'hA000_0001);
        chk("t1_c2_pc", pc_o, 32'h4);
        tick();

        // Three stall cycles at pc 8
        for (int j = 0; j < 4; j++) begin
            at_neg(0, 0, j < 3);
            chk("t2_hold_instr", instr_o, 32'hA000_0002);
            chk("t2_hold_pc", pc_o, 32'h8);
            chk("t2_hold_addr", imem_addr_o, 32'h3);
            tick();
        end
        at_neg(0, 0, 0);
        chk("t2_rel_pc", pc_o, 32'hC);
        chk("t2_rel_instr", instr_o, 32'hA000_0003);
        tick();

        // Redirect during stall
        cyc(1, 32'h8, 0);
        cyc(0, 0, 0);
        at_neg(1, 32'h40, 1);
        chk("t3_pre_pc", pc_o, 32'h8);
        tick();
        at_neg(0, 0, 0);
        chk("t3_fill_valid", {31'h0, valid_o}, 32'h0);
        chk("t3_fill_addr", imem_addr_o, 32'h10);
        tick();
        at_neg(0, 0, 0);
        chk("t3_pc", pc_o, 32'h40);
        chk("t3_instr", instr_o, 32'hA000_0010);
        tick();

        // Run off the end of memory
        for (int k = 0; k < 64 && !(m_valid && m_pc == 32'h7C); k++) cyc(0, 0, 0);
        at_neg(0, 0, 0);
        chk("t4_last_pc", pc_o, 32'h7C);
        chk("t4_last_instr", instr_o, 32'hA000_001F);
        tick();
        at_neg(0, 0, 0);
        chk("t4_valid", {31'h0, valid_o}, 32'h0);
        chk("t4_fault", {31'h0, fault_o}, 32'h1);
        chk("t4_fault_pc", fault_pc_o, 32'h80);
        tick();
        at_neg(1, 32'h0, 1);
        tick();
        at_neg(0, 0, 0);
        chk("t4_clr_fault", {31'h0, fault_o}, 32'h0);
        chk("t4_clr_valid", {31'h0, valid_o}, 32'h0);
        tick();
        at_neg(0, 0, 0);
        chk("t4_restart_pc", pc_o, 32'h0);
        chk("t4_restart_valid", {31'h0, valid_o}, 32'h1);
        tick();

        // Illegal redirect targets
        at_neg(1, 32'h42, 0);
        tick();
        at_neg(1, 32'h200, 0);
        chk("t5_mis_fault", {31'h0, fault_o}, 32'h1);
        chk("t5_mis_fault_pc", fault_pc_o, 32'h42);
        chk("t5_mis_valid", {31'h0, valid_o}, 32'h0);
        tick();
        at_neg(0, 0, 1);
        chk("t5_oor_fault", {31'h0, fault_o}, 32'h1);
        chk("t5_oor_fault_pc", fault_pc_o, 32'h200);
        chk("t5_oor_valid", {31'h0, valid_o}, 32'h0);
        tick();

        // Asynchronous reset while holding
        cyc(1, 32'h10, 0);
        cyc(0, 0, 0);
        at_neg(0, 0, 1);
        tick();
        chk("t6_in_hold_pc", pc_o, 32'h10);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", {31'h0, valid_o}, 32'h0);
        chk("t6_rst_instr", instr_o, 32'h0);
        chk("t6_rst_pc", pc_o, 32'h0);
        chk("t6_rst_fault", {31'h0, fault_o}, 32'h0);
        chk("t6_rst_fault_pc", fault_pc_o, 32'h0);
        chk("t6_rst_addr", imem_addr_o, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        at_neg(0, 0, 0);
        chk("t6_fill_valid", {31'h0, valid_o}, 32'h0);
        tick();
        at_neg(0, 0, 0);
        chk("t6_pc", pc_o, 32'h0);
        chk("t6_instr", instr_o, 32'hA000_0000);
        tick();

        // Random redirect/stall traffic
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 7) == 0);
            s    = ($urandom_range(0, 2) == 0);
            kind = $urandom_range(0, 9);
            rpc  = 32'($urandom_range(0, DEPTH - 1)) << 2;
            if (kind == 7) rpc = rpc | 32'($urandom_range(1, 3));
            else if (kind == 8) rpc = 4 * DEPTH + (32'($urandom_range(0, 100)) << 2);
            else if (kind == 9) rpc = 4 * DEPTH - 8;
            cyc(r, rpc, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
